seg_scan_driver: RTL

//   Time-multiplexed driver for the 4-digit 7-segment display, downstream of the service muxing in Main.

---
 rtl/seg_scan_driver_pkg.sv | 34 +++
 rtl/seg_scan_driver_bcd_to_seg7.sv | 25 ++
 rtl/seg_scan_driver.sv | 129 ++++++++++++
 3 files changed

// File: rtl/seg_scan_driver_pkg.sv
// Shared constants for the 4-digit 7-segment scan driver:
// anode patterns (active-low) and segment codes {g,f,e,d,c,b,a}.
package seg_scan_driver_pkg;

   localparam logic [3:0] ANODE_OFF = 4'b1111;
   localparam logic [3:0] ANODE_D0  = 4'b1110;
   localparam logic [3:0] ANODE_D1  = 4'b1101;
   localparam logic [3:0] ANODE_D2  = 4'b1011;
   localparam logic [3:0] ANODE_D3  = 4'b0111;

   localparam logic [6:0] SEG_BLANK = 7'b0000000;
   localparam logic [6:0] SEG_0     = 7'b0111111;
   localparam logic [6:0] SEG_1     = 7'b0000110;
   localparam logic [6:0] SEG_2     = 7'b1011011;
   localparam logic [6:0] SEG_3     = 7'b1001111;
   localparam logic [6:0] SEG_4     = 7'b1100110;
   localparam logic [6:0] SEG_5     = 7'b1101101;
   localparam logic [6:0] SEG_6     = 7'b1111101;
   localparam logic [6:0] SEG_7     = 7'b0000111;
   localparam logic [6:0] SEG_8     = 7'b1111111;
   localparam logic [6:0] SEG_9     = 7'b1101111;

   function automatic logic [3:0] anode_for(input logic [1:0] idx);
      logic [3:0] a;
      unique case (idx)
         2'd0: a = ANODE_D0;
         2'd1: a = ANODE_D1;
         2'd2: a = ANODE_D2;
         2'd3: a = ANODE_D3;
      endcase
      return a;
   endfunction

endpackage

// File: rtl/seg_scan_driver_bcd_to_seg7.sv
// BCD nibble to 7-segment pattern; non-decimal nibbles render blank.
module bcd_to_seg7
   import seg_scan_driver_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      unique case (nibble)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 4-digit 7-segment driver with a double-buffered
// display word, per-digit blink, decimal points and leading-zero blanking.
module seg_scan_driver
   import seg_scan_driver_pkg::*;
#(
   parameter int SCAN_DIV     = 65536,
   parameter int BLINK_FRAMES = 128
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [15:0] num_in,
   input  logic        load,
   input  logic [3:0]  sel,
   input  logic        blink_en,
   input  logic [3:0]  dp_mask,
   input  logic        blank_lz,
   output logic [3:0]  anode,
   output logic [7:0]  eSeg,
   output logic        load_ack,
   output logic        frame_done
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [DW-1:0] DIV_LAST   = DW'(SCAN_DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

   logic [DW-1:0] div_cnt_q, div_cnt_d;
   logic [1:0]    idx_q, idx_d;
   logic [15:0]   shadow_q, shadow_d;
   logic [15:0]   pend_q, pend_d;
   logic          pend_valid_q, pend_valid_d;
   logic [BW-1:0] blink_cnt_q, blink_cnt_d;
   logic          blink_phase_q, blink_phase_d;
   logic [3:0]    anode_q, anode_d;
   logic [7:0]    eseg_q, eseg_d;

   logic       tick;
   logic       frame_end;
   logic [3:0] digit;
   logic [6:0] seg;
   logic       lz_zero;
   logic       suppress;

   bcd_to_seg7 u_dec (
      .nibble (digit),
      .seg    (seg)
   );

   always_comb begin
      tick      = (div_cnt_q == DIV_LAST);
      frame_end = tick && (idx_q == 2'd3);
      div_cnt_d = tick ? '0 : div_cnt_q + DW'(1);
      idx_d     = tick ? idx_q + 2'd1 : idx_q;

      // A load coinciding with the frame boundary bypasses pend.
      pend_d       = pend_q;
      pend_valid_d = pend_valid_q;
      shadow_d     = shadow_q;
      if (frame_end) begin
         pend_valid_d = 1'b0;
         if (load)
            shadow_d = num_in;
         else if (pend_valid_q)
            shadow_d = pend_q;
      end else if (load) begin
         pend_d       = num_in;
         pend_valid_d = 1'b1;
      end

      blink_cnt_d   = blink_cnt_q;
      blink_phase_d = blink_phase_q;
      if (frame_end) begin
         if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
         end else begin
            blink_cnt_d = blink_cnt_q + BW'(1);
         end
      end

      digit = shadow_q[{idx_q, 2'b00} +: 4];
      unique case (idx_q)
         2'd3:    lz_zero = (shadow_q[15:12] == 4'd0);
         2'd2:    lz_zero = (shadow_q[15:8] == 8'd0);
         2'd1:    lz_zero = (shadow_q[15:4] == 12'd0);
         default: lz_zero = 1'b0;
      endcase
      suppress = (blank_lz && lz_zero)
               || (blink_en && sel[idx_q] && blink_phase_q);

      anode_d = anode_q;
      eseg_d  = eseg_q;
      if (tick) begin
         anode_d = suppress ? ANODE_OFF : anode_for(idx_q);
         eseg_d  = suppress ? 8'h00 : {dp_mask[idx_q], seg};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         div_cnt_q     <= '0;
         idx_q         <= 2'd0;
         shadow_q      <= 16'h0000;
         pend_q        <= 16'h0000;
         pend_valid_q  <= 1'b0;
         blink_cnt_q   <= '0;
         blink_phase_q <= 1'b0;
         anode_q       <= ANODE_OFF;
         eseg_q        <= 8'h00;
      end else begin
         div_cnt_q     <= div_cnt_d;
         idx_q         <= idx_d;
         shadow_q      <= shadow_d;
         pend_q        <= pend_d;
         pend_valid_q  <= pend_valid_d;
         blink_cnt_q   <= blink_cnt_d;
         blink_phase_q <= blink_phase_d;
         anode_q       <= anode_d;
         eseg_q        <= eseg_d;
      end
   end

   assign anode      = anode_q;
   assign eSeg       = eseg_q;
   assign frame_done = frame_end;
   assign load_ack   = frame_end && (load || pend_valid_q);

endmodule
